// File: rtl/biu_arbiter_if.sv
// Requester and BIU signals shared by biu_arbiter.
// The arbiter takes the slave view; a requester/BIU model takes the master view.
interface biu_arbiter_if;

    logic        f_req;
    logic [15:0] f_addr;
    logic        f_gnt;
    logic        f_done;

    logic        e_req;
    logic        e_we;
    logic [15:0] e_addr;
    logic [15:0] e_wdata;
    logic        e_gnt;
    logic        e_done;

    logic [15:0] rdata;
    logic        err;

    logic        biu_cs;
    logic [1:0]  biu_sel;
    logic [15:0] biu_addr;
    logic [15:0] biu_wdata;
    logic        biu_ready;
    logic [15:0] biu_rdata;

    modport slave (
        input  f_req, f_addr, e_req, e_we, e_addr, e_wdata, biu_ready, biu_rdata,
        output f_gnt, f_done, e_gnt, e_done, rdata, err,
               biu_cs, biu_sel, biu_addr, biu_wdata
    );

    modport master (
        output f_req, f_addr, e_req, e_we, e_addr, e_wdata, biu_ready, biu_rdata,
        input  f_gnt, f_done, e_gnt, e_done, rdata, err,
               biu_cs, biu_sel, biu_addr, biu_wdata
    );

endinterface

// File: rtl/biu_arbiter.sv
// Shares the single BIU between instruction fetch and execute load/store.
// Execute has priority; a streak limit forces a fetch grant so fetch never starves.
module biu_arbiter #(
    parameter int unsigned MAX_EX_STREAK = 4,
    parameter int unsigned WAIT_LIMIT    = 255
) (
    input logic          clk,
    input logic          reset,
    biu_arbiter_if.slave bus
);

    localparam int unsigned SW       = (MAX_EX_STREAK > 0) ? $clog2(MAX_EX_STREAK + 1) : 1;
    localparam int unsigned LimitEff = (WAIT_LIMIT > 0) ? WAIT_LIMIT : 1;
    localparam int unsigned TW       = (LimitEff > 1) ? $clog2(LimitEff) : 1;

    localparam logic [SW-1:0] StreakMax = SW'(MAX_EX_STREAK);
    localparam logic [TW-1:0] TmoLast   = TW'(LimitEff - 1);

    localparam logic [1:0] SelIdle  = 2'b00;
    localparam logic [1:0] SelRead  = 2'b01;
    localparam logic [1:0] SelWrite = 2'b10;
    localparam logic [1:0] SelFetch = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StAck,
        StWait,
        StDone
    } state_e;

    state_e        state_q;
    logic [SW-1:0] streak_q;
    logic [TW-1:0] tmo_q;
    logic          f_gnt_q;
    logic          e_gnt_q;
    logic          f_done_q;
    logic          e_done_q;
    logic          err_q;
    logic          cs_q;
    logic [1:0]    sel_q;
    logic [15:0]   addr_q;
    logic [15:0]   wdata_q;
    logic [15:0]   rdata_q;

    logic grant_f;
    logic grant_e;
    logic timeout;
    logic is_write;

    always_comb begin
        grant_f = 1'b0;
        grant_e = 1'b0;
        if (bus.e_req && bus.f_req) begin
            if (streak_q < StreakMax) begin
                grant_e = 1'b1;
            end else begin
                grant_f = 1'b1;
            end
        end else if (bus.e_req) begin
            grant_e = 1'b1;
        end else if (bus.f_req) begin
            grant_f = 1'b1;
        end
    end

    // tmo_q counts completed ACK/WAIT cycles; the last allowed one aborts the transaction.
    assign timeout  = (tmo_q == TmoLast);
    assign is_write = (sel_q == SelWrite);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            streak_q <= '0;
            tmo_q    <= '0;
            f_gnt_q  <= 1'b0;
            e_gnt_q  <= 1'b0;
            f_done_q <= 1'b0;
            e_done_q <= 1'b0;
            err_q    <= 1'b0;
            cs_q     <= 1'b0;
            sel_q    <= SelIdle;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            cs_q     <= 1'b0;
            f_done_q <= 1'b0;
            e_done_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (grant_f || grant_e) begin
                        f_gnt_q <= grant_f;
                        e_gnt_q <= grant_e;
                        cs_q    <= 1'b1;
                        state_q <= StIssue;
                        if (grant_f) begin
                            sel_q    <= SelFetch;
                            addr_q   <= bus.f_addr;
                            streak_q <= '0;
                        end else begin
                            sel_q    <= bus.e_we ? SelWrite : SelRead;
                            addr_q   <= bus.e_addr;
                            wdata_q  <= bus.e_wdata;
                            // Only grants that made fetch wait count toward the streak.
                            streak_q <= bus.f_req ? streak_q + 1'b1 : '0;
                        end
                    end
                end
                StIssue: begin
                    tmo_q   <= '0;
                    state_q <= StAck;
                end
                StAck, StWait: begin
                    if (state_q == StWait && bus.biu_ready) begin
                        if (!is_write) begin
                            rdata_q <= bus.biu_rdata;
                        end
                        f_done_q <= f_gnt_q;
                        e_done_q <= e_gnt_q;
                        sel_q    <= SelIdle;
                        state_q  <= StDone;
                    end else if (timeout) begin
                        rdata_q  <= 16'hFFFF;
                        err_q    <= 1'b1;
                        f_done_q <= f_gnt_q;
                        e_done_q <= e_gnt_q;
                        sel_q    <= SelIdle;
                        state_q  <= StDone;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                        if (state_q == StAck && !bus.biu_ready) begin
                            state_q <= StWait;
                        end
                    end
                end
                StDone: begin
                    f_gnt_q <= 1'b0;
                    e_gnt_q <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.f_gnt     = f_gnt_q;
    assign bus.e_gnt     = e_gnt_q;
    assign bus.f_done    = f_done_q;
    assign bus.e_done    = e_done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.biu_cs    = cs_q;
    assign bus.biu_sel   = sel_q;
    assign bus.biu_addr  = addr_q;
    assign bus.biu_wdata = wdata_q;

    assert property (@(posedge clk) disable iff (reset) cs_q |=> !cs_q);
    assert property (@(posedge clk) disable iff (reset) !(f_gnt_q && e_gnt_q));

endmodule

// File: tb/tb_biu_arbiter.sv
// Directed bench for biu_arbiter: bench drives both requesters and models the BIU,
// all sampling and driving on the falling clock edge.
module tb_biu_arbiter;

    localparam logic [1:0] SelIdle  = 2'b00;
    localparam logic [1:0] SelRead  = 2'b01;
    localparam logic [1:0] SelWrite = 2'b10;
    localparam logic [1:0] SelFetch = 2'b11;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    biu_arbiter_if bus ();

    biu_arbiter #(
        .MAX_EX_STREAK(4),
        .WAIT_LIMIT   (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_cs(output int n);
        n = 0;
        while (bus.biu_cs !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
    endtask

    // One transaction: ready drops one cycle after cs, stays low three cycles, then returns.
    // drop[1] releases f_req and drop[0] releases e_req on the done cycle.
    task automatic serve(input string tag, input logic is_f, input logic [1:0] sel,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] rd_in, input logic [15:0] exp_rdata,
                         input logic [1:0] drop);
        int n;
        wait_cs(n);
        check({tag, ".cs_latency"}, 16'(n), 16'd1);
        check({tag, ".f_gnt"}, 16'(bus.f_gnt), 16'(is_f));
        check({tag, ".e_gnt"}, 16'(bus.e_gnt), 16'(!is_f));
        check({tag, ".sel"}, 16'(bus.biu_sel), 16'(sel));
        check({tag, ".addr"}, bus.biu_addr, addr);
        @(negedge clk);
        check({tag, ".cs_one_cycle"}, 16'(bus.biu_cs), 16'd0);
        bus.biu_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check({tag, ".sel_wait"}, 16'(bus.biu_sel), 16'(sel));
        check({tag, ".addr_wait"}, bus.biu_addr, addr);
        if (sel == SelWrite) begin
            check({tag, ".wdata_wait"}, bus.biu_wdata, wdata);
        end
        @(negedge clk);
        check({tag, ".no_early_done"}, 16'(bus.f_done | bus.e_done), 16'd0);
        bus.biu_ready = 1'b1;
        bus.biu_rdata = rd_in;
        @(negedge clk);
        check({tag, ".f_done"}, 16'(bus.f_done), 16'(is_f));
        check({tag, ".e_done"}, 16'(bus.e_done), 16'(!is_f));
        check({tag, ".err"}, 16'(bus.err), 16'd0);
        check({tag, ".rdata"}, bus.rdata, exp_rdata);
        check({tag, ".sel_done"}, 16'(bus.biu_sel), 16'(SelIdle));
        if (drop[1]) bus.f_req = 1'b0;
        if (drop[0]) bus.e_req = 1'b0;
        @(negedge clk);
        check({tag, ".done_pulse"}, 16'(bus.f_done | bus.e_done), 16'd0);
        check({tag, ".gnt_drop"}, 16'(bus.f_gnt | bus.e_gnt), 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [9:0] order_f;
        order_f = 10'b10_0001_0000;

        reset         = 1'b1;
        bus.f_req     = 1'b0;
        bus.f_addr    = '0;
        bus.e_req     = 1'b0;
        bus.e_we      = 1'b0;
        bus.e_addr    = '0;
        bus.e_wdata   = '0;
        bus.biu_ready = 1'b1;
        bus.biu_rdata = '0;
        repeat (2) @(negedge clk);

        check("rst.f_gnt", 16'(bus.f_gnt), 16'd0);
        check("rst.e_gnt", 16'(bus.e_gnt), 16'd0);
        check("rst.done", 16'(bus.f_done | bus.e_done), 16'd0);
        check("rst.err", 16'(bus.err), 16'd0);
        check("rst.cs", 16'(bus.biu_cs), 16'd0);
        check("rst.sel", 16'(bus.biu_sel), 16'(SelIdle));
        check("rst.addr", bus.biu_addr, 16'h0000);
        check("rst.wdata", bus.biu_wdata, 16'h0000);
        check("rst.rdata", bus.rdata, 16'h0000);
        reset = 1'b0;
        @(negedge clk);
        check("idle.cs", 16'(bus.biu_cs), 16'd0);

        // Single fetch read.
        bus.f_req  = 1'b1;
        bus.f_addr = 16'h0010;
        serve("t1", 1'b1, SelFetch, 16'h0010, 16'h0000, 16'hA5A5, 16'hA5A5, 2'b10);

        // Execute write leaves rdata alone.
        bus.e_req   = 1'b1;
        bus.e_we    = 1'b1;
        bus.e_addr  = 16'h0200;
        bus.e_wdata = 16'h1234;
        serve("t4", 1'b0, SelWrite, 16'h0200, 16'h1234, 16'hDEAD, 16'hA5A5, 2'b01);

        // Simultaneous requests: execute first, fetch in the following arbitration.
        bus.e_we   = 1'b0;
        bus.e_addr = 16'h0300;
        bus.f_addr = 16'h0040;
        bus.f_req  = 1'b1;
        bus.e_req  = 1'b1;
        serve("t2.e", 1'b0, SelRead, 16'h0300, 16'h0000, 16'h1111, 16'h1111, 2'b01);
        serve("t2.f", 1'b1, SelFetch, 16'h0040, 16'h0000, 16'h2222, 16'h2222, 2'b10);

        // Both held back-to-back: E,E,E,E,F,E,E,E,E,F.
        bus.e_addr = 16'h0400;
        bus.f_addr = 16'h0080;
        bus.f_req  = 1'b1;
        bus.e_req  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            serve($sformatf("t3.%0d", i), order_f[i], order_f[i] ? SelFetch : SelRead,
                  order_f[i] ? 16'h0080 : 16'h0400, 16'h0000, 16'h1000 + 16'(i),
                  16'h1000 + 16'(i), (i == 9) ? 2'b11 : 2'b00);
        end

        // BIU never returns ready: abort after 8 cycles in ACK+WAIT.
        bus.e_req  = 1'b1;
        bus.e_we   = 1'b0;
        bus.e_addr = 16'h0500;
        wait_cs(n);
        check("t5.cs_latency", 16'(n), 16'd1);
        @(negedge clk);
        bus.biu_ready = 1'b0;
        repeat (7) @(negedge clk);
        check("t5.no_early_done", 16'(bus.e_done), 16'd0);
        check("t5.no_early_err", 16'(bus.err), 16'd0);
        @(negedge clk);
        check("t5.e_done", 16'(bus.e_done), 16'd1);
        check("t5.err", 16'(bus.err), 16'd1);
        check("t5.rdata", bus.rdata, 16'hFFFF);
        bus.e_req     = 1'b0;
        bus.biu_ready = 1'b1;
        @(negedge clk);
        check("t5.err_pulse", 16'(bus.err), 16'd0);
        check("t5.done_pulse", 16'(bus.e_done), 16'd0);

        // Reset during WAIT aborts without a done pulse.
        bus.f_req  = 1'b1;
        bus.f_addr = 16'h0600;
        wait_cs(n);
        check("t6.cs_latency", 16'(n), 16'd1);
        @(negedge clk);
        bus.biu_ready = 1'b0;
        @(negedge clk);
        check("t6.f_gnt_wait", 16'(bus.f_gnt), 16'd1);
        reset     = 1'b1;
        bus.f_req = 1'b0;
        @(negedge clk);
        check("t6.f_gnt", 16'(bus.f_gnt), 16'd0);
        check("t6.cs", 16'(bus.biu_cs), 16'd0);
        check("t6.sel", 16'(bus.biu_sel), 16'(SelIdle));
        check("t6.f_done", 16'(bus.f_done), 16'd0);
        check("t6.addr", bus.biu_addr, 16'h0000);
        check("t6.rdata", bus.rdata, 16'h0000);
        reset         = 1'b0;
        bus.biu_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t6.no_done.%0d", i), 16'(bus.f_done | bus.e_done), 16'd0);
        end
        bus.f_req  = 1'b1;
        bus.f_addr = 16'h0700;
        serve("t6.fresh", 1'b1, SelFetch, 16'h0700, 16'h0000, 16'h3C3C, 16'h3C3C, 2'b10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
